serial_add_sub32: RTL

SERIAL_ADD_SUB32 -- requirements
Module: serial_add_sub32

---
 rtl/add_sub_pkg.sv | 19 +
 rtl/addsub_slice.sv | 32 +++
 rtl/serial_add_sub32.sv | 126 ++++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package add_sub_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation encodings on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default geometry: 32-bit operands processed 4 bits per cycle.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit ripple-carry slice. Also exports the carry into
// its top bit so the caller can form signed overflow on the final digit.
module addsub_slice
  import add_sub_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] w_c;

  // Ripple the carry through the digit one bit at a time.
  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  end

  assign cout  = w_c[DIGIT];
  assign c_top = w_c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub32.sv
// Digit-serial two's complement adder/subtractor.
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready is high only in IDLE, out_valid only in
// DONE, and the result holds stable in DONE until it is taken.
// Subtraction is A + ~B + 1: B is inverted at accept time and the carry
// register is seeded with op, so one slice serves both operations.
module serial_add_sub32
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output state_t           o_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_cy;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    w_base;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_ctop;
  logic             w_last;

  // Bit offset of the digit being processed this RUN cycle.
  assign w_base = IW'(r_cnt) * IW'(DIGIT);
  assign w_last = (r_cnt == LAST);

  addsub_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a    (r_a[w_base +: DIGIT]),
    .b    (r_b[w_base +: DIGIT]),
    .cin  (r_cy),
    .sum  (w_sum),
    .cout (w_cout),
    .c_top(w_ctop)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and digit-serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cy  <= 1'b0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= (op == OP_SUB) ? ~B : B;
            r_cy  <= op;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_res[w_base +: DIGIT] <= w_sum;
          r_cy                   <= w_cout;
          if (w_last) r_ovf <= w_ctop ^ w_cout;
          else        r_cnt <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = r_res;
  assign carry_out = r_cy;
  assign overflow  = r_ovf;
  assign o_state   = r_state;

endmodule
